wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Parametrised N-master Wishbone arbiter with round-robin fairness, grant hold for multi-beat (burst) cycles, and a per-grant watchdog that aborts a stalled transfer with an error. It sits between the J1 cores' data (or instruction) master ports and a single shared Wishbone slave. It replaces the fixed 4-core arbiter in designs that need more cores, wider buses, or protection against hung slaves.

## Interface
- NUM_M, 4: number of masters (≥2).
- DATA_W, 16: data bus width.
- ADR_W, 16: address bus width.
- TIMEOUT, 64: cycles without `s_ack` before abort; 0 disables the watchdog.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- m_cyc  in  NUM_M  per-master cycle request.
- m_stb  in  NUM_M  per-master strobe.
- m_we  in  NUM_M  per-master write enable.
- m_adr  in  NUM_M*ADR_W  flattened addresses; master i at [i*ADR_W +: ADR_W].
- m_dat_o  in  NUM_M*DATA_W  flattened write data.
- m_dat_i  out  NUM_M*DATA_W  read data; `s_dat_i` for the granted master, zero for all others.
- m_ack  out  NUM_M  `s_ack` routed to the granted master only.
- m_err  out  NUM_M  one-cycle abort pulse to the granted master.
- s_cyc, s_stb, s_we  out  1  shared slave controls.
- s_adr  out  ADR_W; s_dat_o  out  DATA_W  shared slave address/data.
- s_dat_i  in  DATA_W; s_ack  in  1  slave response.
- grant  out  NUM_M  one-hot registered grant; all-zero when idle.

## Operation
- States: IDLE, GRANT, ERR.
- Reset: state IDLE, grant 0, last-grant pointer NUM_M-1, watchdog 0. All outputs are 0.
- Round-robin pick: search starts at pointer+1 mod NUM_M and wraps. The first master with `m_cyc`=1 wins. After reset, master 0 has top priority.
- IDLE: if any `m_cyc` is high, load the picked master into `grant` and the pointer, then go to GRANT.
- GRANT:
  - `s_cyc` = `m_cyc[g]`; `s_stb` = `m_stb[g]`; `s_we`, `s_adr`, and `s_dat_o` come from master g.
  - All four are forced to 0 outside GRANT.
  - The grant is held while `m_cyc[g]` stays high, across any number of acks (bursts and RMW cycles are never split).
- Release in GRANT: when `m_cyc[g]`=0 at an edge, re-pick among the current requests (master g has lowest priority). Load the new grant with no idle gap, or go to IDLE if there are no requests.
- Watchdog:
  - Counter width is $clog2(TIMEOUT+1).
  - Clears on a new grant and on `s_ack`.
  - Increments each GRANT cycle with `s_stb`=1 and `s_ack`=0.
  - On reaching TIMEOUT-1 with no ack, the next state is ERR.
- ERR (one cycle):
  - `m_err[g]`=1; `s_cyc`/`s_stb`=0.
  - The pointer is already at g.
  - Then re-pick as on release. Master g is not excluded; if it still holds `m_cyc`, it is re-granted only after all other requesters are served.
- `s_ack` arriving in ERR or IDLE is dropped; no `m_ack` is raised.
- `rst` mid-transfer: grant is dropped at that edge. `s_cyc` and `grant` are 0 the following cycle.

## Timing
- Request to grant: 1 cycle (request sampled at edge k, `grant`/`s_cyc` valid after edge k).
- Ack path: combinational, `s_ack` to `m_ack[g]` and `s_dat_i` to `m_dat_i`, with zero latency.
- Handover: the master dropping `m_cyc` in cycle k means the next master is driving the bus in cycle k+1.
- Abort: the `m_err` pulse occurs exactly TIMEOUT cycles after the last grant or ack with the strobe pending.
- `grant`, state, pointer, and watchdog are registered. Slave-side outputs are combinational from registered `grant`.

## Structure
- Package `wb_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT, ERR}
  - function `rr_next(req, ptr)` returning a one-hot grant
  - localparam for the watchdog width
- Sub-module `rr_picker`: combinational round-robin priority pick (req[NUM_M], ptr → one-hot, any). Instantiated once, shared by IDLE, release and ERR exits.

## Test plan
- Reset, then `m_cyc`=4'b1111 with each master holding for 1 ack then releasing → grant order 0,1,2,3,0, no idle cycle between grants.
- Master 2 holds `m_cyc` across 4 acks while master 1 requests → master 1 is not granted until master 2 drops `m_cyc`; all 4 `m_ack` go to master 2 only.
- TIMEOUT=8, master 0 strobes and the slave never acks → `m_err[0]` pulses 8 cycles after grant, `s_cyc`=0 for that cycle, and master 1 (pending) is granted next.
- Master 3 read with `s_dat_i`=16'hBEEF → `m_dat_i` of master 3 = BEEF, all other master slices 0, `m_ack` only on bit 3.
- `rst` asserted while master 1 is mid-transfer → next cycle `grant`=0 and `s_cyc`=0; after reset, master 0 wins a 0/1 tie.
- NUM_M=6, DATA_W=32, TIMEOUT=0 → masters 0–5 rotate fairly; a stalled slave never raises `m_err`.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// The pick function is sized for up to MAX_M masters and narrowed by the caller.
package wb_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, ERR} arb_state_t;

    localparam int MAX_M       = 32;
    localparam int IDX_W       = $clog2(MAX_M);
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_WD_W    = $clog2(DEF_TIMEOUT + 1);

    // A zero timeout still needs a one-bit counter to keep the declaration legal.
    function automatic int wd_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    // Search begins just after ptr and wraps, so the master at ptr has lowest priority.
    function automatic logic [MAX_M-1:0] rr_next(input logic [MAX_M-1:0] req,
                                                 input int unsigned ptr,
                                                 input int unsigned n);
        logic [MAX_M-1:0] gnt;
        logic             found;
        logic [IDX_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= MAX_M; off++) begin
            if (off <= n) begin
                idx = IDX_W'((ptr + off) % n);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_M-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_M; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_picker.sv
// Combinational round-robin pick: one-hot winner among req, starting after ptr.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_M = 4,
    parameter int PTR_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NUM_M-1:0] gnt,
    output logic             any_req
);

    logic [MAX_M-1:0] req_ext;
    logic [MAX_M-1:0] gnt_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[NUM_M-1:0]  = req;
        gnt_ext             = rr_next(req_ext, 32'(ptr), NUM_M);
    end

    assign gnt     = gnt_ext[NUM_M-1:0];
    assign any_req = |gnt_ext;

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master Wishbone round-robin arbiter with burst grant hold and a per-grant
// stall watchdog that aborts the granted master with a one-cycle m_err.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int DATA_W  = 16,
    parameter int ADR_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_cyc,
    input  logic [NUM_M-1:0]          m_stb,
    input  logic [NUM_M-1:0]          m_we,
    input  logic [NUM_M*ADR_W-1:0]    m_adr,
    input  logic [NUM_M*DATA_W-1:0]   m_dat_o,
    output logic [NUM_M*DATA_W-1:0]   m_dat_i,
    output logic [NUM_M-1:0]          m_ack,
    output logic [NUM_M-1:0]          m_err,
    output logic                      s_cyc,
    output logic                      s_stb,
    output logic                      s_we,
    output logic [ADR_W-1:0]          s_adr,
    output logic [DATA_W-1:0]         s_dat_o,
    input  logic [DATA_W-1:0]         s_dat_i,
    input  logic                      s_ack,
    output logic [NUM_M-1:0]          grant
);

    localparam int PTR_W = $clog2(NUM_M);
    localparam int WD_W  = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [WD_W-1:0]  wd_q,    wd_d;

    logic [NUM_M-1:0] pick_gnt;
    logic             pick_any;
    logic [MAX_M-1:0] pick_ext;
    logic [PTR_W-1:0] pick_idx;

    logic              g_cyc, g_stb, g_we;
    logic [ADR_W-1:0]  g_adr;
    logic [DATA_W-1:0] g_dat;
    logic              in_grant;

    // The pointer always holds the last granted master, so one picker serves
    // the idle start, the release handover and the post-abort re-pick alike.
    rr_picker #(.NUM_M(NUM_M), .PTR_W(PTR_W)) u_picker (
        .req     (m_cyc),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .any_req (pick_any)
    );

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q[i]) begin
                g_cyc = g_cyc | m_cyc[i];
                g_stb = g_stb | m_stb[i];
                g_we  = g_we  | m_we[i];
                g_adr = g_adr | m_adr[i*ADR_W +: ADR_W];
                g_dat = g_dat | m_dat_o[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(NUM_M - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        ptr_d               = ptr_q;
        wd_d                = wd_q;
        pick_ext            = '0;
        pick_ext[NUM_M-1:0] = pick_gnt;
        pick_idx            = PTR_W'(onehot_idx(pick_ext));

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_gnt;
                    ptr_d   = pick_idx;
                    wd_d    = '0;
                end
            end
            GRANT: begin
                if (!g_cyc) begin
                    wd_d = '0;
                    if (pick_any) begin
                        grant_d = pick_gnt;
                        ptr_d   = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (s_ack) begin
                    wd_d = '0;
                end else if (g_stb && (TIMEOUT != 0)) begin
                    if (wd_q == WD_LIMIT) begin
                        state_d = ERR;
                        wd_d    = '0;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
            end
            ERR: begin
                wd_d = '0;
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_gnt;
                    ptr_d   = pick_idx;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                wd_d    = '0;
            end
        endcase
    end

    assign in_grant = (state_q == GRANT);

    assign s_cyc   = in_grant & g_cyc;
    assign s_stb   = in_grant & g_stb;
    assign s_we    = in_grant & g_we;
    assign s_adr   = in_grant ? g_adr : '0;
    assign s_dat_o = in_grant ? g_dat : '0;

    assign m_ack = (in_grant && s_ack) ? grant_q : '0;
    assign m_err = (state_q == ERR)    ? grant_q : '0;
    assign grant = grant_q;

    always_comb begin
        m_dat_i = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q[i]) m_dat_i[i*DATA_W +: DATA_W] = s_dat_i;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a 4-master instance with an 8-cycle watchdog
// and a 6-master, 32-bit instance with the watchdog disabled.
module tb_wb_rr_arbiter;

    localparam int AM = 4;
    localparam int AD = 16;
    localparam int AA = 16;
    localparam int AT = 8;
    localparam int BM = 6;
    localparam int BD = 32;
    localparam int BA = 16;

    logic clk;
    logic rst;

    logic [AM-1:0]    a_cyc, a_stb, a_we, a_ack, a_err, a_grant;
    logic [AM*AA-1:0] a_adr;
    logic [AM*AD-1:0] a_dat_o, a_dat_i;
    logic             a_scyc, a_sstb, a_swe, a_sack;
    logic [AA-1:0]    a_sadr;
    logic [AD-1:0]    a_sdat_o, a_sdat_i;

    logic [BM-1:0]    b_cyc, b_stb, b_we, b_ack, b_err, b_grant;
    logic [BM*BA-1:0] b_adr;
    logic [BM*BD-1:0] b_dat_o, b_dat_i;
    logic             b_scyc, b_sstb, b_swe, b_sack;
    logic [BA-1:0]    b_sadr;
    logic [BD-1:0]    b_sdat_o, b_sdat_i;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    wb_rr_arbiter #(.NUM_M(AM), .DATA_W(AD), .ADR_W(AA), .TIMEOUT(AT)) dut_a (
        .clk(clk), .rst(rst),
        .m_cyc(a_cyc), .m_stb(a_stb), .m_we(a_we), .m_adr(a_adr),
        .m_dat_o(a_dat_o), .m_dat_i(a_dat_i), .m_ack(a_ack), .m_err(a_err),
        .s_cyc(a_scyc), .s_stb(a_sstb), .s_we(a_swe), .s_adr(a_sadr),
        .s_dat_o(a_sdat_o), .s_dat_i(a_sdat_i), .s_ack(a_sack), .grant(a_grant)
    );

    wb_rr_arbiter #(.NUM_M(BM), .DATA_W(BD), .ADR_W(BA), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .m_cyc(b_cyc), .m_stb(b_stb), .m_we(b_we), .m_adr(b_adr),
        .m_dat_o(b_dat_o), .m_dat_i(b_dat_i), .m_ack(b_ack), .m_err(b_err),
        .s_cyc(b_scyc), .s_stb(b_sstb), .s_we(b_swe), .s_adr(b_sadr),
        .s_dat_o(b_sdat_o), .s_dat_i(b_sdat_i), .s_ack(b_sack), .grant(b_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish before 100000");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int g;
        int errseen;
        int seq_a[5];
        int seq_b[7];
        seq_a = '{0, 1, 2, 3, 0};
        seq_b = '{0, 1, 2, 3, 4, 5, 0};

        rst = 1'b1;
        a_cyc = '0; a_stb = '0; a_we = '0; a_sack = 1'b0; a_sdat_i = '0;
        b_cyc = '0; b_stb = '0; b_we = '0; b_sack = 1'b0; b_sdat_i = '0;
        for (int i = 0; i < AM; i++) begin
            a_adr[i*AA +: AA]   = 16'(16'h1000 + i);
            a_dat_o[i*AD +: AD] = 16'(16'hA000 + i);
        end
        for (int i = 0; i < BM; i++) begin
            b_adr[i*BA +: BA]   = 16'(16'h2000 + i);
            b_dat_o[i*BD +: BD] = 32'(32'hD0000000 + i);
        end
        repeat (2) tick();

        chk("rst_grant", a_grant, 0);
        chk("rst_scyc", a_scyc, 0);
        chk("rst_err", a_err, 0);
        chk("rst_ack", a_ack, 0);
        chk("rst_dat", a_dat_i, 0);
        chk("rst_b_grant", b_grant, 0);
        rst = 1'b0;

        // Rotation 0,1,2,3,0 with one ack per grant and immediate re-request.
        a_cyc = 4'hF; a_stb = 4'hF; a_we = 4'b0101;
        exp_q.push_back(seq_a[0]);
        tick();
        for (int i = 0; i < 5; i++) begin
            g = exp_q.pop_front();
            chk("t1_grant", a_grant, 1 << g);
            chk("t1_scyc", a_scyc, 1);
            chk("t1_sadr", a_sadr, 16'h1000 + g);
            chk("t1_sdat", a_sdat_o, 16'hA000 + g);
            a_sack = 1'b1;
            #1;
            chk("t1_ack", a_ack, 1 << g);
            tick();
            a_sack = 1'b0;
            a_cyc[g] = 1'b0;
            if (i == 4) a_cyc = '0;
            else exp_q.push_back(seq_a[i+1]);
            tick();
            if (i != 4) a_cyc[g] = 1'b1;
        end
        chk("t1_idle", a_grant, 0);
        a_stb = '0; a_we = '0;

        // Master 2 bursts four beats while master 1 waits.
        a_cyc = 4'b0100; a_stb = 4'b0100;
        tick();
        chk("t2_grant", a_grant, 4'b0100);
        a_cyc[1] = 1'b1; a_stb[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_sack = 1'b1;
            a_sdat_i = 16'(16'h5A00 + k);
            exp_q.push_back(2);
            #1;
            g = exp_q.pop_front();
            chk("t2_ack", a_ack, 1 << g);
            chk("t2_hold", a_grant, 4'b0100);
            chk("t2_dat", a_dat_i, {16'h0, 16'(16'h5A00 + k), 32'h0});
            tick();
        end
        a_sack = 1'b0;
        a_cyc[2] = 1'b0; a_stb[2] = 1'b0;
        tick();
        chk("t2_handover", a_grant, 4'b0010);
        a_cyc[1] = 1'b0; a_stb[1] = 1'b0;
        tick();
        chk("t2_idle", a_grant, 0);

        // Master 0 stalls; watchdog aborts after 8 cycles, pending master 1 follows.
        a_cyc = 4'b0001; a_stb = 4'b0001;
        tick();
        chk("t3_grant", a_grant, 4'b0001);
        a_cyc[1] = 1'b1;
        for (int c = 1; c <= AT; c++) begin
            chk("t3_no_err", a_err, 0);
            chk("t3_scyc", a_scyc, 1);
            tick();
        end
        a_sack = 1'b1;
        #1;
        chk("t3_err", a_err, 4'b0001);
        chk("t3_err_scyc", a_scyc, 0);
        chk("t3_err_sstb", a_sstb, 0);
        chk("t3_ack_drop", a_ack, 0);
        a_sack = 1'b0;
        tick();
        chk("t3_err_gone", a_err, 0);
        chk("t3_next", a_grant, 4'b0010);
        a_cyc = '0; a_stb = '0;
        tick();
        chk("t3_idle", a_grant, 0);

        // Master 3 read returns BEEF on its slice only.
        a_cyc = 4'b1000; a_stb = 4'b1000; a_we = '0;
        tick();
        chk("t4_grant", a_grant, 4'b1000);
        a_sdat_i = 16'hBEEF;
        a_sack = 1'b1;
        #1;
        chk("t4_dat", a_dat_i, {16'hBEEF, 48'h0});
        chk("t4_ack", a_ack, 4'b1000);
        chk("t4_sadr", a_sadr, 16'h1003);
        chk("t4_swe", a_swe, 0);
        tick();
        a_sack = 1'b0; a_sdat_i = '0;
        a_cyc = '0; a_stb = '0;
        tick();
        chk("t4_idle", a_grant, 0);

        // Reset in the middle of master 1's transfer.
        a_cyc = 4'b0010; a_stb = 4'b0010;
        tick();
        chk("t5_grant", a_grant, 4'b0010);
        chk("t5_scyc", a_scyc, 1);
        rst = 1'b1;
        a_cyc = 4'b0011; a_stb = 4'b0011;
        tick();
        chk("t5_rst_grant", a_grant, 0);
        chk("t5_rst_scyc", a_scyc, 0);
        rst = 1'b0;
        tick();
        chk("t5_tie", a_grant, 4'b0001);
        a_cyc = '0; a_stb = '0;
        tick();

        // Six masters, watchdog off: long stall then fair rotation.
        b_cyc = 6'h3F; b_stb = 6'h3F;
        tick();
        chk("t6_grant0", b_grant, 6'b000001);
        errseen = 0;
        repeat (80) begin
            if (b_err != '0) errseen++;
            tick();
        end
        chk("t6_no_err", errseen, 0);
        chk("t6_hold", b_grant, 6'b000001);
        exp_q.push_back(seq_b[0]);
        for (int i = 0; i < 7; i++) begin
            g = exp_q.pop_front();
            chk("t6_grant", b_grant, 1 << g);
            b_sack = 1'b1;
            b_sdat_i = 32'(32'hC0DE0000 + g);
            #1;
            chk("t6_ack", b_ack, 1 << g);
            chk("t6_dat", b_dat_i[g*BD +: BD], 32'hC0DE0000 + g);
            tick();
            b_sack = 1'b0;
            b_cyc[g] = 1'b0;
            if (i == 6) b_cyc = '0;
            else exp_q.push_back(seq_b[i+1]);
            tick();
            if (i != 6) b_cyc[g] = 1'b1;
        end
        chk("t6_idle", b_grant, 0);
        chk("t6_err_end", b_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
